// File: rtl/timer_counter.sv
// Up/down timer-counter with periodic or one-shot mode, terminal-count pulse and sticky done flag.
// Optional step prescaler is compiled in with `define TIMER_COUNTER_PRESCALE_EN.
module timer_counter #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned PRESCALE = 100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] reset_val,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit_val,
  input  logic             load,
  input  logic             inc,
  input  logic             dir,
  input  logic             mode,
  input  logic             clr_done,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             done
);

  logic             tick;
  logic             at_term;
  logic             halted;
  logic             step;
  logic [WIDTH-1:0] nxt;
  logic             nxt_term;

  // PRESCALE below 1 is unsupported; this empty scope marks such an elaboration.
  if (PRESCALE < 1) begin : g_prescale_unsupported
  end

`ifdef TIMER_COUNTER_PRESCALE_EN
  localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] psc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     psc <= '0;
    else if (load) psc <= '0;
    else if (inc)  psc <= (psc == PS_MAX) ? '0 : psc + PS_W'(1);
  end

  assign tick = (psc == PS_MAX);
`else
  assign tick = 1'b1;
`endif

  assign at_term  = dir ? (count == '0) : (count >= limit_val);
  assign halted   = mode & at_term;
  assign step     = inc & ~load & tick & ~halted;
  // Only a periodic counter can step while at terminal, so this wrap term never fires in one-shot.
  assign nxt      = at_term ? (dir ? limit_val : '0)
                            : (dir ? count - WIDTH'(1) : count + WIDTH'(1));
  assign nxt_term = dir ? (nxt == '0) : (nxt >= limit_val);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= reset_val;
      tc    <= 1'b0;
      done  <= 1'b0;
    end else if (load) begin
      count <= load_val;
      tc    <= 1'b0;
      done  <= 1'b0;
    end else begin
      tc <= step & nxt_term;
      if (step) count <= nxt;
      if (step & mode & nxt_term) done <= 1'b1;
      else if (clr_done)          done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: directed scenarios plus randomized traffic vs. a reference model.
module tb_timer_counter;
  localparam int W = 8;
  localparam int M = 256;
  localparam int P = 4;
`ifdef TIMER_COUNTER_PRESCALE_EN
  localparam bit PS_EN = 1'b1;
`else
  localparam bit PS_EN = 1'b0;
`endif

  logic         clk, reset, load, inc, dir, mode, clr_done;
  logic [W-1:0] reset_val, load_val, limit_val;
  logic [W-1:0] count;
  logic         tc, done;

  int n_vec = 0;
  int n_err = 0;

  int m_cnt, m_psc;
  bit m_tc, m_done;

  timer_counter #(.WIDTH(W), .PRESCALE(P)) dut (
    .clk(clk), .reset(reset), .reset_val(reset_val), .load_val(load_val),
    .limit_val(limit_val), .load(load), .inc(inc), .dir(dir), .mode(mode),
    .clr_done(clr_done), .count(count), .tc(tc), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit is_term(input int c);
    return dir ? (c == 0) : (c >= int'(limit_val));
  endfunction

  task automatic model_reset();
    m_cnt = int'(reset_val); m_tc = 0; m_done = 0; m_psc = 0;
  endtask

  // Reference behaviour for one rising clock edge with the inputs currently applied.
  task automatic model_edge();
    bit tick_ok, go;
    int nx;
    if (reset) model_reset();
    else if (load) begin
      m_cnt = int'(load_val); m_tc = 0; m_done = 0; m_psc = 0;
    end else begin
      tick_ok = PS_EN ? (m_psc == P - 1) : 1'b1;
      go = inc && tick_ok && !(mode && is_term(m_cnt));
      if (inc) m_psc = (m_psc + 1) % P;
      if (go) begin
        if (is_term(m_cnt)) nx = dir ? int'(limit_val) : 0;
        else                nx = (m_cnt + (dir ? -1 : 1) + M) % M;
        m_cnt = nx;
        m_tc  = is_term(nx);
        if (mode && m_tc) m_done = 1;
        else if (clr_done) m_done = 0;
      end else begin
        m_tc = 0;
        if (clr_done) m_done = 0;
      end
    end
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk); #1;
    chk("count", 32'(count), 32'(m_cnt));
    chk("tc", 32'(tc), 32'(m_tc));
    chk("done", 32'(done), 32'(m_done));
  endtask

  task automatic exp_state(input int c, input bit t, input bit d);
    cyc();
    chk("count_dir", 32'(count), 32'(c));
    chk("tc_dir", 32'(tc), 32'(t));
    chk("done_dir", 32'(done), 32'(d));
  endtask

  initial begin
    reset = 1; reset_val = 8'd5; load_val = '0; limit_val = '0;
    load = 0; inc = 0; dir = 0; mode = 0; clr_done = 0;
    model_reset();
    #2;
    chk("rst_count", 32'(count), 32'd5);
    chk("rst_tc", 32'(tc), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    reset = 0;
    chk("rel_count", 32'(count), 32'd5);

`ifndef TIMER_COUNTER_PRESCALE_EN
    // Periodic up, limit 7
    limit_val = 8'd7; inc = 1;
    exp_state(6, 0, 0); exp_state(7, 1, 0); exp_state(0, 0, 0); exp_state(1, 0, 0);
    // Periodic down, limit 3, from 1; load wins over a concurrent step
    dir = 1; limit_val = 8'd3; load_val = 8'd1; load = 1;
    exp_state(1, 0, 0); load = 0;
    exp_state(0, 1, 0); exp_state(3, 0, 0); exp_state(2, 0, 0);
    // One-shot up to 4, hold, then clear done
    dir = 0; mode = 1; limit_val = 8'd4; load_val = 8'd2; load = 1;
    exp_state(2, 0, 0); load = 0;
    exp_state(3, 0, 0); exp_state(4, 1, 1); exp_state(4, 0, 1); exp_state(4, 0, 1);
    clr_done = 1; exp_state(4, 0, 0); clr_done = 0;
    // done set coinciding with clr_done: set wins
    load_val = 8'd3; load = 1; exp_state(3, 0, 0); load = 0;
    clr_done = 1; exp_state(4, 1, 1); clr_done = 0;
    // Load with inc high clears done and tc
    mode = 0; limit_val = 8'd11; load_val = 8'd9; load = 1;
    exp_state(9, 0, 0); load = 0;
    exp_state(10, 0, 0); exp_state(11, 1, 0);
    // Asynchronous reset pulse between edges while tc is high
    #3 reset = 1;
    #1;
    chk("async_count", 32'(count), 32'd5);
    chk("async_tc", 32'(tc), 32'd0);
    chk("async_done", 32'(done), 32'd0);
    model_reset();
    #2 reset = 0;
    exp_state(6, 0, 0);
    // limit 0 up: every step lands on 0 with tc
    limit_val = 8'd0;
    exp_state(0, 1, 0); exp_state(0, 1, 0);
    // load above limit is terminal; next step wraps to 0
    limit_val = 8'd5; load_val = 8'd9; load = 1;
    exp_state(9, 0, 0); load = 0;
    exp_state(0, 0, 0); exp_state(1, 0, 0);
`else
    // One step per 4 enabled cycles; a 2-cycle inc gap delays the next step by 2
    limit_val = 8'd100; load_val = 8'd0; load = 1; inc = 1;
    exp_state(0, 0, 0); load = 0;
    for (int i = 1; i <= 10; i++) exp_state(i / 4, 0, 0);
    inc = 0;
    exp_state(2, 0, 0); exp_state(2, 0, 0);
    inc = 1;
    exp_state(2, 0, 0); exp_state(3, 0, 0); exp_state(3, 0, 0);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      reset    = ($urandom_range(0, 39) == 0);
      load     = ($urandom_range(0, 7) == 0);
      inc      = ($urandom_range(0, 3) != 0);
      clr_done = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0) dir  = $urandom_range(0, 1);
      if ($urandom_range(0, 9) == 0) mode = $urandom_range(0, 1);
      if ($urandom_range(0, 7) == 0) limit_val = W'($urandom_range(0, 15));
      load_val = ($urandom_range(0, 5) == 0) ? W'($urandom_range(250, 255))
                                             : W'($urandom_range(0, 20));
      cyc();
    end
    reset = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/timer_counter.md
TIMER_COUNTER -- requirements
Module: timer_counter

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the counter, load, reset and limit widths.
REQ-002 Parameter PRESCALE, default 100, SHALL set the clock cycles per count step when the prescaler is compiled in (minimum 1).
REQ-003 clk  input  1  SHALL be the system clock; all state changes except reset occur on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 reset_val  input  WIDTH  SHALL be the value count takes on reset.
REQ-006 load_val  input  WIDTH  SHALL be the value loaded when load is high.
REQ-007 limit_val  input  WIDTH  SHALL be the up-count terminal value and the down-count wrap value.
REQ-008 load  input  1  SHALL be the active-high synchronous load strobe.
REQ-009 inc  input  1  SHALL be the active-high count enable.
REQ-010 dir  input  1  SHALL select direction: 0 up, 1 down.
REQ-011 mode  input  1  SHALL select mode: 0 periodic (wrap), 1 one-shot (stop at terminal).
REQ-012 clr_done  input  1  SHALL clear the done flag synchronously.
REQ-013 count  output  WIDTH  SHALL be the registered counter value.
REQ-014 tc  output  1  SHALL be the registered one-cycle terminal-count pulse.
REQ-015 done  output  1  SHALL be the sticky one-shot-complete flag.

Function
REQ-016 A "step" SHALL occur on a clk edge when inc=1, load=0, the step tick is active, and the counter is not halted.
REQ-017 The terminal condition SHALL be count>=limit_val when dir=0 and count==0 when dir=1.
REQ-018 On a step in periodic mode, a counter at terminal SHALL wrap: to 0 when dir=0, to limit_val when dir=1.
REQ-019 On a step in periodic mode, a counter not at terminal SHALL move by 1: +1 when dir=0, -1 when dir=1.
REQ-020 In one-shot mode, the counter SHALL be halted while the terminal condition holds, and steps SHALL be ignored.
REQ-021 tc SHALL be 1 for exactly the cycle after any step whose result meets the terminal condition, and 0 otherwise.
REQ-022 In one-shot mode, a step whose result meets the terminal condition SHALL set done, and done SHALL hold until cleared.
REQ-023 done SHALL be cleared by clr_done or load.
REQ-024 If set and clr_done coincide, set SHALL win.
REQ-025 load SHALL have priority over a step: count<=load_val, tc<=0, and the prescaler is cleared, regardless of inc.
REQ-026 Changes to dir, mode or limit_val SHALL take effect from the next step; no state is flushed.
REQ-027 A load_val above limit_val in up mode SHALL be terminal, so the next periodic step wraps to 0.
REQ-028 With limit_val=0 and dir=0, every periodic step SHALL yield count=0 and tc=1.
REQ-029 Arithmetic SHALL be unsigned modulo 2^WIDTH with no carry out.

Reset
REQ-030 reset=1 SHALL immediately set count=reset_val, tc=0, done=0 and prescaler=0, independent of clk.
REQ-031 Reset asserted mid-count or mid-prescale SHALL abandon the operation, and counting SHALL resume from reset_val on the first eligible step after release.

Configuration
REQ-032 Macro TIMER_COUNTER_PRESCALE_EN SHALL control the prescaler.
REQ-033 With TIMER_COUNTER_PRESCALE_EN defined, an internal prescaler SHALL count 0..PRESCALE-1 on clk edges where inc=1, and the step tick SHALL be active only when it equals PRESCALE-1 (one step per PRESCALE enabled cycles).
REQ-034 With TIMER_COUNTER_PRESCALE_EN defined, the prescaler SHALL hold while inc=0 and clear on load or reset.
REQ-035 Without TIMER_COUNTER_PRESCALE_EN, the step tick SHALL be constantly active, no prescaler logic SHALL exist, and PRESCALE SHALL be ignored.

Verification
REQ-036 The bench SHALL cover, without prescaler: WIDTH=8, reset_val=5, release reset, inc=1, dir=0, mode=0, limit=7 -> count 5,6,7,0,1; tc high on the cycle after count becomes 7.
REQ-037 The bench SHALL cover, without prescaler: dir=1, mode=0, limit=3, load_val=1 -> count 1,0,3,2; tc pulse after 0.
REQ-038 The bench SHALL cover, without prescaler: mode=1, dir=0, limit=4, load 2, inc=1 -> count 2,3,4 then holds 4; done=1; tc single pulse; clr_done -> done=0, count stays 4.
REQ-039 The bench SHALL cover simultaneous load=1 and inc=1 with load_val=9 -> count=9, tc=0, done=0.
REQ-040 The bench SHALL cover an async reset pulse mid-count (not clock aligned) -> count=reset_val immediately and tc=0, done=0.
REQ-041 The bench SHALL cover, with TIMER_COUNTER_PRESCALE_EN and PRESCALE=4: inc=1 -> count advances once per 4 clk; dropping inc for 2 cycles mid-prescale delays the next step by exactly 2 cycles.
